// File: rtl/load_store_queue_pkg.sv
// Shared definitions for the load/store queue: default sizes, access-width
// codes and the memory-sequencer state type.
package load_store_queue_pkg;
  localparam int XLEN_DEF      = 32;
  localparam int TAG_W_DEF     = 5;
  localparam int LSQ_DEPTH_DEF = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } lsq_state_e;
endpackage

// File: rtl/load_store_queue_load_extend.sv
// Sign/zero extension of returned load data according to the access width.
module load_extend
  import load_store_queue_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] val_o
);
  always_comb begin
    val_o = rdata_i;
    case (funct3_i)
      F3_B:    val_o = {{(XLEN-8){rdata_i[7]}}, rdata_i[7:0]};
      F3_H:    val_o = {{(XLEN-16){rdata_i[15]}}, rdata_i[15:0]};
      F3_BU:   val_o = {{(XLEN-8){1'b0}}, rdata_i[7:0]};
      F3_HU:   val_o = {{(XLEN-16){1'b0}}, rdata_i[15:0]};
      F3_W:    val_o = rdata_i;
      default: val_o = rdata_i;
    endcase
  end
endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue: snoops two result buses, holds stores until ROB
// commit and issues one memory access at a time from the queue head.
module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int LSQ_DEPTH = LSQ_DEPTH_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int XLEN      = XLEN_DEF
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             issue_en,
  input  logic             issue_is_store,
  input  logic [2:0]       issue_funct3,
  input  logic [XLEN-1:0]  issue_imm,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [TAG_W-1:0] issue_q1,
  input  logic [TAG_W-1:0] issue_q2,
  input  logic [XLEN-1:0]  issue_v1,
  input  logic [XLEN-1:0]  issue_v2,
  output logic             full,
  input  logic             cdb0_en,
  input  logic [TAG_W-1:0] cdb0_tag,
  input  logic [XLEN-1:0]  cdb0_val,
  input  logic             cdb1_en,
  input  logic [TAG_W-1:0] cdb1_tag,
  input  logic [XLEN-1:0]  cdb1_val,
  input  logic             rob_commit_en,
  input  logic [TAG_W-1:0] rob_commit_tag,
  output logic             mem_req_en,
  output logic             mem_req_we,
  output logic [XLEN-1:0]  mem_req_addr,
  output logic [2:0]       mem_req_funct3,
  output logic [XLEN-1:0]  mem_req_wdata,
  input  logic             mem_busy,
  input  logic             mem_done,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             ld_out_en,
  output logic [TAG_W-1:0] ld_out_tag,
  output logic [XLEN-1:0]  ld_out_val
);
  localparam int PTR_W = $clog2(LSQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [LSQ_DEPTH-1:0] valid_q, valid_d, store_q, store_d, cmt_q, cmt_d;
  logic [2:0]       f3_q  [LSQ_DEPTH], f3_d  [LSQ_DEPTH];
  logic [XLEN-1:0]  imm_q [LSQ_DEPTH], imm_d [LSQ_DEPTH];
  logic [XLEN-1:0]  v1_q  [LSQ_DEPTH], v1_d  [LSQ_DEPTH];
  logic [XLEN-1:0]  v2_q  [LSQ_DEPTH], v2_d  [LSQ_DEPTH];
  logic [TAG_W-1:0] tag_q [LSQ_DEPTH], tag_d [LSQ_DEPTH];
  logic [TAG_W-1:0] q1_q  [LSQ_DEPTH], q1_d  [LSQ_DEPTH];
  logic [TAG_W-1:0] q2_q  [LSQ_DEPTH], q2_d  [LSQ_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, ncmt;
  lsq_state_e       state_q, state_d;

  logic             infl_ld_q, infl_ld_d, kill_q, kill_d;
  logic [TAG_W-1:0] infl_tag_q, infl_tag_d;
  logic [2:0]       infl_f3_q, infl_f3_d;

  logic             mem_req_en_q, mem_req_en_d, mem_req_we_q, mem_req_we_d;
  logic [XLEN-1:0]  mem_req_addr_q, mem_req_addr_d, mem_req_wdata_q, mem_req_wdata_d;
  logic [2:0]       mem_req_funct3_q, mem_req_funct3_d;
  logic             ld_out_en_q, ld_out_en_d;
  logic [TAG_W-1:0] ld_out_tag_q, ld_out_tag_d;
  logic [XLEN-1:0]  ld_out_val_q, ld_out_val_d, ext_val;

  logic             head_rdy, fire, done, accept;
  logic [TAG_W-1:0] iq1, iq2;
  logic [XLEN-1:0]  iv1, iv2;

  function automatic logic hit(input logic [TAG_W-1:0] q, input logic en,
                               input logic [TAG_W-1:0] t);
    return en && (q != '0) && (q == t);
  endfunction

  assign full = (count_q == CNT_W'(LSQ_DEPTH));

  always_comb begin : head_check
    head_rdy = valid_q[head_q] && (q1_q[head_q] == '0) &&
               (!store_q[head_q] || ((q2_q[head_q] == '0) && cmt_q[head_q]));
  end

  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (head_rdy && !mem_busy) state_d = ST_WAIT_MEM;
      ST_WAIT_MEM: if (mem_done) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin : fsm_out
    fire = (state_q == ST_IDLE) && head_rdy && !mem_busy;
    done = (state_q == ST_WAIT_MEM) && mem_done;
  end

  always_comb begin : issue_bypass
    iq1 = issue_q1;
    iv1 = issue_v1;
    iq2 = issue_q2;
    iv2 = issue_v2;
    if (hit(issue_q1, cdb0_en, cdb0_tag)) begin iq1 = '0; iv1 = cdb0_val; end
    else if (hit(issue_q1, cdb1_en, cdb1_tag)) begin iq1 = '0; iv1 = cdb1_val; end
    if (hit(issue_q2, cdb0_en, cdb0_tag)) begin iq2 = '0; iv2 = cdb0_val; end
    else if (hit(issue_q2, cdb1_en, cdb1_tag)) begin iq2 = '0; iv2 = cdb1_val; end
  end

  always_comb begin : entry_next
    valid_d = valid_q;  store_d = store_q;  cmt_d = cmt_q;
    f3_d = f3_q;  imm_d = imm_q;  tag_d = tag_q;
    q1_d = q1_q;  q2_d = q2_q;  v1_d = v1_q;  v2_d = v2_q;
    head_d = head_q;  tail_d = tail_q;  count_d = count_q;
    ncmt = '0;
    accept = issue_en && !full && !flush;
    for (int i = 0; i < LSQ_DEPTH; i++) begin
      if (valid_q[i]) begin
        if (hit(q1_q[i], cdb0_en, cdb0_tag)) begin q1_d[i] = '0; v1_d[i] = cdb0_val; end
        else if (hit(q1_q[i], cdb1_en, cdb1_tag)) begin q1_d[i] = '0; v1_d[i] = cdb1_val; end
        if (hit(q2_q[i], cdb0_en, cdb0_tag)) begin q2_d[i] = '0; v2_d[i] = cdb0_val; end
        else if (hit(q2_q[i], cdb1_en, cdb1_tag)) begin q2_d[i] = '0; v2_d[i] = cdb1_val; end
        if (store_q[i] && rob_commit_en && (rob_commit_tag == tag_q[i])) cmt_d[i] = 1'b1;
      end
    end
    if (fire) begin
      valid_d[head_q] = 1'b0;
      cmt_d[head_q]   = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (flush) begin
      // Committed stores always form a prefix from head, so they stay contiguous.
      for (int i = 0; i < LSQ_DEPTH; i++) begin
        if (!cmt_d[i]) valid_d[i] = 1'b0;
        if (valid_d[i]) ncmt = ncmt + CNT_W'(1);
      end
      tail_d  = head_d + ncmt[PTR_W-1:0];
      count_d = ncmt;
    end else begin
      if (accept) begin
        valid_d[tail_q] = 1'b1;
        store_d[tail_q] = issue_is_store;
        cmt_d[tail_q]   = 1'b0;
        f3_d[tail_q]    = issue_funct3;
        imm_d[tail_q]   = issue_imm;
        tag_d[tail_q]   = issue_tag;
        q1_d[tail_q]    = iq1;
        v1_d[tail_q]    = iv1;
        q2_d[tail_q]    = iq2;
        v2_d[tail_q]    = iv2;
        tail_d          = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(accept) - CNT_W'(fire);
    end
  end

  load_extend #(.XLEN(XLEN)) u_ext (
    .funct3_i (infl_f3_q),
    .rdata_i  (mem_rdata),
    .val_o    (ext_val)
  );

  always_comb begin : port_next
    mem_req_en_d     = fire;
    mem_req_we_d     = mem_req_we_q;
    mem_req_addr_d   = mem_req_addr_q;
    mem_req_funct3_d = mem_req_funct3_q;
    mem_req_wdata_d  = mem_req_wdata_q;
    infl_ld_d  = infl_ld_q;
    infl_tag_d = infl_tag_q;
    infl_f3_d  = infl_f3_q;
    kill_d     = kill_q;
    if (fire) begin
      mem_req_we_d     = store_q[head_q];
      mem_req_addr_d   = v1_q[head_q] + imm_q[head_q];
      mem_req_funct3_d = f3_q[head_q];
      mem_req_wdata_d  = store_q[head_q] ? v2_q[head_q] : '0;
      infl_ld_d        = !store_q[head_q];
      infl_tag_d       = tag_q[head_q];
      infl_f3_d        = f3_q[head_q];
      kill_d           = 1'b0;
    end
    // A flushed load still finishes on the bus, but its result is dropped.
    if (flush) kill_d = 1'b1;
    ld_out_en_d  = done && infl_ld_q && !kill_q && !flush;
    ld_out_tag_d = ld_out_tag_q;
    ld_out_val_d = ld_out_val_q;
    if (ld_out_en_d) begin
      ld_out_tag_d = infl_tag_q;
      ld_out_val_d = ext_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      valid_q <= '0;  cmt_q <= '0;
      head_q <= '0;  tail_q <= '0;  count_q <= '0;
      state_q <= ST_IDLE;
      infl_ld_q <= 1'b0;  kill_q <= 1'b0;
      mem_req_en_q <= 1'b0;  mem_req_we_q <= 1'b0;
      mem_req_addr_q <= '0;  mem_req_funct3_q <= '0;  mem_req_wdata_q <= '0;
      ld_out_en_q <= 1'b0;  ld_out_tag_q <= '0;  ld_out_val_q <= '0;
    end else if (rdy_in) begin
      valid_q <= valid_d;  cmt_q <= cmt_d;
      head_q <= head_d;  tail_q <= tail_d;  count_q <= count_d;
      state_q <= state_d;
      infl_ld_q <= infl_ld_d;  kill_q <= kill_d;
      mem_req_en_q <= mem_req_en_d;  mem_req_we_q <= mem_req_we_d;
      mem_req_addr_q <= mem_req_addr_d;  mem_req_funct3_q <= mem_req_funct3_d;
      mem_req_wdata_q <= mem_req_wdata_d;
      ld_out_en_q <= ld_out_en_d;  ld_out_tag_q <= ld_out_tag_d;  ld_out_val_q <= ld_out_val_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy_in) begin
      store_q <= store_d;  f3_q <= f3_d;  imm_q <= imm_d;  tag_q <= tag_d;
      q1_q <= q1_d;  q2_q <= q2_d;  v1_q <= v1_d;  v2_q <= v2_d;
      infl_tag_q <= infl_tag_d;  infl_f3_q <= infl_f3_d;
    end
  end

  assign mem_req_en     = mem_req_en_q;
  assign mem_req_we     = mem_req_we_q;
  assign mem_req_addr   = mem_req_addr_q;
  assign mem_req_funct3 = mem_req_funct3_q;
  assign mem_req_wdata  = mem_req_wdata_q;
  assign ld_out_en      = ld_out_en_q;
  assign ld_out_tag     = ld_out_tag_q;
  assign ld_out_val     = ld_out_val_q;
endmodule

// File: tb/tb_load_store_queue.sv
// Scoreboard bench for load_store_queue: stimulus pushes expected memory
// requests and load results, a monitor pops and compares them as they appear.
module tb_load_store_queue;
  logic        clk, rst_in, rdy_in, flush;
  logic        issue_en, issue_is_store;
  logic [2:0]  issue_funct3;
  logic [31:0] issue_imm, issue_v1, issue_v2;
  logic [4:0]  issue_tag, issue_q1, issue_q2;
  logic        full;
  logic        cdb0_en, cdb1_en;
  logic [4:0]  cdb0_tag, cdb1_tag;
  logic [31:0] cdb0_val, cdb1_val;
  logic        rob_commit_en;
  logic [4:0]  rob_commit_tag;
  logic        mem_req_en, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [2:0]  mem_req_funct3;
  logic        mem_busy, mem_done;
  logic [31:0] mem_rdata;
  logic        ld_out_en;
  logic [4:0]  ld_out_tag;
  logic [31:0] ld_out_val;

  load_store_queue #(.LSQ_DEPTH(8), .TAG_W(5), .XLEN(32)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .issue_en(issue_en), .issue_is_store(issue_is_store), .issue_funct3(issue_funct3),
    .issue_imm(issue_imm), .issue_tag(issue_tag), .issue_q1(issue_q1), .issue_q2(issue_q2),
    .issue_v1(issue_v1), .issue_v2(issue_v2), .full(full),
    .cdb0_en(cdb0_en), .cdb0_tag(cdb0_tag), .cdb0_val(cdb0_val),
    .cdb1_en(cdb1_en), .cdb1_tag(cdb1_tag), .cdb1_val(cdb1_val),
    .rob_commit_en(rob_commit_en), .rob_commit_tag(rob_commit_tag),
    .mem_req_en(mem_req_en), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_funct3(mem_req_funct3), .mem_req_wdata(mem_req_wdata),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ld_out_en(ld_out_en), .ld_out_tag(ld_out_tag), .ld_out_val(ld_out_val)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
  } mem_exp_t;
  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] val;
  } ld_exp_t;

  mem_exp_t    exp_mem[$];
  ld_exp_t     exp_ld[$];
  logic [31:0] rdata_q[$];
  int pass_cnt = 0, total_cnt = 0;
  int mem_cnt = 0, ld_cnt = 0;
  int cyc = 0, last_done_cyc = -10;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
  endtask

  // Memory responder: one idle cycle after a request, then a one-cycle done.
  initial begin : mem_model
    logic [31:0] rd;
    mem_done = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req_en === 1'b1) begin
        rd = 32'h0;
        if (!mem_req_we && rdata_q.size() > 0) rd = rdata_q.pop_front();
        @(negedge clk);
        mem_done = 1'b1;
        mem_rdata = rd;
        last_done_cyc = cyc;
        @(negedge clk);
        mem_done = 1'b0;
        mem_rdata = '0;
      end
    end
  end

  initial begin : monitor
    mem_exp_t m;
    ld_exp_t  l;
    forever begin
      @(negedge clk);
      if (mem_req_en === 1'b1) begin
        mem_cnt++;
        if (exp_mem.size() == 0) begin
          total_cnt++;
          $display("FAIL mem_req_unexpected: got addr 0x%08h we %0d, required no request",
                   mem_req_addr, mem_req_we);
        end else begin
          m = exp_mem.pop_front();
          chk("mem_we", {31'b0, mem_req_we}, {31'b0, m.we});
          chk("mem_addr", mem_req_addr, m.addr);
          chk("mem_funct3", {29'b0, mem_req_funct3}, {29'b0, m.f3});
          if (m.we) chk("mem_wdata", mem_req_wdata, m.wdata);
        end
      end
      if (ld_out_en === 1'b1) begin
        ld_cnt++;
        if (exp_ld.size() == 0) begin
          total_cnt++;
          $display("FAIL ld_out_unexpected: got tag %0d val 0x%08h, required none",
                   ld_out_tag, ld_out_val);
        end else begin
          l = exp_ld.pop_front();
          chk("ld_tag", {27'b0, ld_out_tag}, {27'b0, l.tag});
          chk("ld_val", ld_out_val, l.val);
          chk("ld_latency", cyc, last_done_cyc + 1);
        end
      end
    end
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] imm,
                       input logic [4:0] tag, input logic [4:0] q1, input logic [4:0] q2,
                       input logic [31:0] v1, input logic [31:0] v2);
    issue_en = 1'b1; issue_is_store = st; issue_funct3 = f3; issue_imm = imm;
    issue_tag = tag; issue_q1 = q1; issue_q2 = q2; issue_v1 = v1; issue_v2 = v2;
    @(negedge clk);
    issue_en = 1'b0;
  endtask

  task automatic commit(input logic [4:0] tag);
    rob_commit_en = 1'b1; rob_commit_tag = tag;
    @(negedge clk);
    rob_commit_en = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_in = 1'b0;
  endtask

  task automatic exp_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] tag,
                          input logic [31:0] rdata, input logic [31:0] val);
    exp_mem.push_back('{we: 1'b0, addr: addr, f3: f3, wdata: 32'h0});
    rdata_q.push_back(rdata);
    exp_ld.push_back('{tag: tag, val: val});
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_mem.size() != 0 || exp_ld.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (exp_mem.size() == 0 && exp_ld.size() == 0) pass_cnt++;
    else $display("FAIL %s_drain: got %0d mem and %0d load results outstanding, required 0",
                  name, exp_mem.size(), exp_ld.size());
    repeat (4) @(negedge clk);
  endtask

  initial begin : stim
    int snap;
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
    issue_en = 1'b0; issue_is_store = 1'b0; issue_funct3 = '0; issue_imm = '0;
    issue_tag = '0; issue_q1 = '0; issue_q2 = '0; issue_v1 = '0; issue_v2 = '0;
    cdb0_en = 1'b0; cdb0_tag = '0; cdb0_val = '0;
    cdb1_en = 1'b0; cdb1_tag = '0; cdb1_val = '0;
    rob_commit_en = 1'b0; rob_commit_tag = '0; mem_busy = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_full", {31'b0, full}, 32'h0);
    chk("rst_mem_req_en", {31'b0, mem_req_en}, 32'h0);
    chk("rst_ld_out_en", {31'b0, ld_out_en}, 32'h0);
    chk("rst_mem_req_addr", mem_req_addr, 32'h0);
    chk("rst_ld_out_val", ld_out_val, 32'h0);
    rst_in = 1'b0;
    @(negedge clk);

    // Basic LW
    exp_load(32'h104, 3'b010, 5'd1, 32'hDEADBEEF, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h4, 5'd1, 5'd0, 5'd0, 32'h100, 32'h0);
    wait_drain("lw");

    // Byte/half extension
    exp_load(32'h200, 3'b000, 5'd2, 32'h00000080, 32'hFFFFFF80);
    exp_load(32'h201, 3'b100, 5'd3, 32'h00000080, 32'h00000080);
    exp_load(32'h202, 3'b001, 5'd6, 32'h00008001, 32'hFFFF8001);
    exp_load(32'h203, 3'b101, 5'd7, 32'h00008001, 32'h00008001);
    issue(1'b0, 3'b000, 32'h0, 5'd2, 5'd0, 5'd0, 32'h200, 32'h0);
    issue(1'b0, 3'b100, 32'h1, 5'd3, 5'd0, 5'd0, 32'h200, 32'h0);
    issue(1'b0, 3'b001, 32'h2, 5'd6, 5'd0, 5'd0, 32'h200, 32'h0);
    issue(1'b0, 3'b101, 32'h3, 5'd7, 5'd0, 5'd0, 32'h200, 32'h0);
    wait_drain("extend");

    // Store: operands from both CDBs in one cycle, then held until commit
    issue(1'b1, 3'b010, 32'h8, 5'd4, 5'd12, 5'd13, 32'h0, 32'h0);
    cdb0_en = 1'b1; cdb0_tag = 5'd12; cdb0_val = 32'h300;
    cdb1_en = 1'b1; cdb1_tag = 5'd13; cdb1_val = 32'hCAFEF00D;
    @(negedge clk);
    cdb0_en = 1'b0; cdb1_en = 1'b0;
    snap = mem_cnt;
    repeat (10) @(negedge clk);
    chk("store_uncommitted_no_req", mem_cnt, snap);
    exp_mem.push_back('{we: 1'b1, addr: 32'h308, f3: 3'b010, wdata: 32'hCAFEF00D});
    commit(5'd4);
    @(negedge clk);
    chk("store_commit_req_en", {31'b0, mem_req_en}, 32'h1);
    chk("store_commit_req_we", {31'b0, mem_req_we}, 32'h1);
    wait_drain("store");

    // Same-cycle CDB bypass on issue
    exp_load(32'h410, 3'b010, 5'd8, 32'h12345678, 32'h12345678);
    cdb0_en = 1'b1; cdb0_tag = 5'd7; cdb0_val = 32'h400;
    issue(1'b0, 3'b010, 32'h10, 5'd8, 5'd7, 5'd0, 32'h00000BAD, 32'h0);
    cdb0_en = 1'b0;
    @(negedge clk);
    chk("bypass_no_stall", {31'b0, mem_req_en}, 32'h1);
    wait_drain("bypass");

    // Reset while a load is outstanding: its late mem_done must be ignored
    exp_mem.push_back('{we: 1'b0, addr: 32'h900, f3: 3'b010, wdata: 32'h0});
    rdata_q.push_back(32'h55555555);
    issue(1'b0, 3'b010, 32'h0, 5'd5, 5'd0, 5'd0, 32'h900, 32'h0);
    @(negedge clk);
    snap = ld_cnt;
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    repeat (8) @(negedge clk);
    chk("reset_abandons_load", ld_cnt, snap);
    chk("reset_full", {31'b0, full}, 32'h0);
    wait_drain("reset_mid");

    // Fill, reject 9th, pop one, wrap to index 0
    do_reset();
    mem_busy = 1'b1;
    exp_load(32'h500, 3'b010, 5'd10, 32'h11110000, 32'h11110000);
    issue(1'b0, 3'b010, 32'h0, 5'd10, 5'd0, 5'd0, 32'h500, 32'h0);
    for (int i = 1; i < 8; i++)
      issue(1'b0, 3'b010, 32'(i * 4), 5'(10 + i), 5'd20, 5'd0, 32'h0, 32'h0);
    chk("fill_full", {31'b0, full}, 32'h1);
    issue(1'b0, 3'b010, 32'h0, 5'd30, 5'd0, 5'd0, 32'h600, 32'h0);
    chk("ninth_rejected_full", {31'b0, full}, 32'h1);
    mem_busy = 1'b0;
    @(negedge clk);
    chk("pop_not_full", {31'b0, full}, 32'h0);
    for (int i = 1; i < 8; i++)
      exp_load(32'h1000 + 32'(i * 4), 3'b010, 5'(10 + i), 32'h22220000 + 32'(i),
               32'h22220000 + 32'(i));
    exp_load(32'h700, 3'b010, 5'd31, 32'h33330000, 32'h33330000);
    issue(1'b0, 3'b010, 32'h0, 5'd31, 5'd0, 5'd0, 32'h700, 32'h0);
    cdb0_en = 1'b1; cdb0_tag = 5'd20; cdb0_val = 32'h1000;
    @(negedge clk);
    cdb0_en = 1'b0;
    wait_drain("wrap");

    // Flush keeps committed stores only
    mem_busy = 1'b1;
    issue(1'b1, 3'b010, 32'h0, 5'd1, 5'd0, 5'd0, 32'h800, 32'hA5A5A5A5);
    issue(1'b1, 3'b001, 32'h4, 5'd2, 5'd0, 5'd0, 32'h800, 32'h00005A5A);
    for (int i = 0; i < 3; i++)
      issue(1'b0, 3'b010, 32'h0, 5'(3 + i), 5'd0, 5'd0, 32'hA00, 32'h0);
    commit(5'd1);
    commit(5'd2);
    do_flush();
    for (int i = 0; i < 5; i++)
      issue(1'b0, 3'b010, 32'h0, 5'(6 + i), 5'd9, 5'd0, 32'h0, 32'h0);
    chk("flush_count2_plus5_not_full", {31'b0, full}, 32'h0);
    issue(1'b0, 3'b010, 32'h0, 5'd11, 5'd9, 5'd0, 32'h0, 32'h0);
    chk("flush_count2_plus6_full", {31'b0, full}, 32'h1);
    do_flush();
    chk("flush_again_not_full", {31'b0, full}, 32'h0);
    exp_mem.push_back('{we: 1'b1, addr: 32'h800, f3: 3'b010, wdata: 32'hA5A5A5A5});
    exp_mem.push_back('{we: 1'b1, addr: 32'h804, f3: 3'b001, wdata: 32'h00005A5A});
    mem_busy = 1'b0;
    wait_drain("flush");
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
